demux_generic_deser: RTL

Bit-serial to parallel deserializer. It takes a 1-bit stream under a valid/ready handshake and steers each accepted bit to an indexed position of an n-bit assembly register. Completed words are presented on a valid/ready parallel output. It is the write-side counterpart of the generic 1-bit select mux, and sits between serial links and word-wide datapaths.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_generic_1bit.sv | 20 ++
 rtl/demux_generic_deser.sv | 105 ++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the bit-serial deserializer family.
// Holds the FSM state type and the write-position mapping used by the top.
package demux_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } demux_state_e;

  // Maps a bit count within the word to the assembly-register bit it lands in.
  function automatic int unsigned bit_pos(input int unsigned idx,
                                          input int unsigned n,
                                          input bit          msb_first);
    return msb_first ? (n - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/demux_generic_1bit.sv
// One-hot write-strobe decoder: the write-side inverse of the 1-bit select mux.
// Raises strobe[idx] when we is high; all strobes are low otherwise.
module demux_generic_1bit #(
  parameter int n = 16
) (
  input  logic [$clog2(n)-1:0] idx,
  input  logic                 we,
  output logic [n-1:0]         strobe
);

  localparam int IW = $clog2(n);

  always_comb begin
    strobe = '0;
    for (int i = 0; i < n; i++) begin
      if (we && (idx == IW'(i))) strobe[i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_generic_deser.sv
// Bit-serial to parallel deserializer with valid/ready on both sides.
// Buffers one word in the output register and one in assembly before stalling.
module demux_generic_deser
  import demux_pkg::*;
#(
  parameter int n         = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 in_start,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [n-1:0]         out_word,
  input  logic                 out_ready,
  output logic [$clog2(n)-1:0] idx,
  output logic                 frame_err
);

  localparam int             IW   = $clog2(n);
  localparam logic [IW-1:0]  LAST = IW'(n - 1);

  demux_state_e   state_q;
  logic [IW-1:0]  idx_q;
  logic [n-1:0]   asm_q;
  logic [n-1:0]   out_word_q;
  logic           out_valid_q;
  logic           frame_err_q;

  logic           accept;
  logic           slot_free;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  wr_pos;
  logic [n-1:0]   strobe;
  logic [n-1:0]   asm_base;
  logic [n-1:0]   asm_w;

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;

  // A frame sync restarts the word: count from zero on an empty assembly.
  assign wr_idx   = in_start ? '0 : idx_q;
  assign wr_pos   = IW'(bit_pos(32'(wr_idx), n, MSB_FIRST != 0));
  assign asm_base = in_start ? '0 : asm_q;
  assign asm_w    = (asm_base & ~strobe) | (strobe & {n{in_bit}});

  demux_generic_1bit #(.n(n)) u_dec (
    .idx    (wr_pos),
    .we     (accept),
    .strobe (strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      asm_q       <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= accept && in_start && (idx_q != '0);
      // Default: a transfer empties the output slot unless a new word lands below.
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            if (wr_idx != LAST) begin
              asm_q <= asm_w;
              idx_q <= wr_idx + 1'b1;
            end else if (slot_free) begin
              out_word_q  <= asm_w;
              out_valid_q <= 1'b1;
              asm_q       <= '0;
              idx_q       <= '0;
            end else begin
              asm_q   <= asm_w;
              idx_q   <= LAST;
              state_q <= FULL;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            out_word_q  <= asm_q;
            out_valid_q <= 1'b1;
            asm_q       <= '0;
            idx_q       <= '0;
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign idx       = idx_q;
  assign frame_err = frame_err_q;

endmodule
